// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and default widths.
package pipe_pkg;

    localparam int unsigned PC_W_DEFAULT = 32;

    // Entries held by a skid stage: none, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel carrying a PC and an opaque payload.
//   valid : producer has an entry
//   ready : consumer can take it
//   pc    : entry PC
//   data  : entry payload, packed by the producing stage
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned PC_W   = PC_W_DEFAULT
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;

    modport master (output valid, output pc, output data, input  ready);
    modport slave  (input  valid, input  pc, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with a two-entry skid buffer.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : drop every held and incoming entry this cycle
//   in_if     : upstream channel (ready is registered)
//   out_if    : downstream channel (pc/data come straight from the main register)
//   occupancy : entries held, 0..2
//   stall_cnt : saturating count of cycles with out_valid & !out_ready
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned PC_W        = PC_W_DEFAULT,
    parameter bit          ZERO_BUBBLE = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_skid_if.slave  in_if,
    pipe_stage_skid_if.master out_if,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_state_t      state_q, state_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        occupancy_q, occupancy_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic xfer_in, xfer_out;

    assign xfer_in  = in_if.valid & in_ready_q;
    assign xfer_out = out_valid_q & out_if.ready;

    // Next state and storage updates; flush overrides the normal transfer.
    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_data_d = main_data_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;

        case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    state_d     = ONE;
                    main_pc_d   = in_if.pc;
                    main_data_d = in_if.data;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    main_pc_d   = in_if.pc;
                    main_data_d = in_if.data;
                end else if (xfer_in) begin
                    state_d     = FULL;
                    skid_pc_d   = in_if.pc;
                    skid_data_d = in_if.data;
                end else if (xfer_out) begin
                    state_d = EMPTY;
                    if (ZERO_BUBBLE) begin
                        main_pc_d   = '0;
                        main_data_d = '0;
                    end
                end
            end
            FULL: begin
                if (xfer_out) begin
                    state_d     = ONE;
                    main_pc_d   = skid_pc_q;
                    main_data_d = skid_data_q;
                    skid_pc_d   = '0;
                    skid_data_d = '0;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (flush) begin
            state_d     = EMPTY;
            main_pc_d   = '0;
            main_data_d = '0;
            skid_pc_d   = '0;
            skid_data_d = '0;
        end
    end

    // Registered status derived from the next state.
    always_comb begin
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
        case (state_d)
            ONE:     occupancy_d = 2'd1;
            FULL:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    // Stall counter ignores flush and saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_if.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_pc_q   <= '0;
            main_data_q <= '0;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_data_q <= main_data_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occupancy_q <= occupancy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid_q;
    assign out_if.pc    = main_pc_q;
    assign out_if.data  = main_data_q;
    assign occupancy    = occupancy_q;
    assign stall_cnt    = stall_cnt_q;

endmodule
